memory_top: RTL and testbench

- Memory stage of the 5-stage RV32 pipeline. Consumes the M-stage bundle produced by the execute stage and performs loads and stores over a req/ack data-memory bus.
- Loads: formats byte/half/word data with sign or zero extension. Stores: generates byte strobes.
- Stalls the pipeline while the bus is busy.
- Registers the M/W pipeline boundary and produces the writeback result. Also returns ReadDataM for M-stage forwarding.

---
 rtl/memory_top.sv | 122 ++++++++++++
 tb/tb_memory_top.sv | 139 +++++++++++++
 2 files changed

// File: rtl/memory_top.sv
// memory_top: RV32 memory stage with req/ack data bus, load formatting,
// store strobes, bus timeout and the M/W pipeline register.
module memory_top #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            MemoryOpM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  MemStallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  misaligned_o,
  output logic                  bus_err_o,
  output logic                  RegWriteW,
  output logic [ADDR_WIDTH-1:0] RdW,
  output logic [DATA_WIDTH-1:0] ResultW
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  bus_err_q, bus_err_d;
  logic                  reg_write_w_q, reg_write_w_d;
  logic [ADDR_WIDTH-1:0] rd_w_q, rd_w_d;
  logic [DATA_WIDTH-1:0] result_w_q, result_w_d;
  logic                  access, mis, req, stall, done;
  logic [1:0]            off, size;
  logic [DATA_WIDTH-1:0] shifted, fmt;
  logic [15:0]           half;
  always_comb begin
    off    = ALUResultM[1:0];
    size   = MemoryOpM[1:0];
    access = MemWriteM | (ResultSrcM == 2'b01);
    mis    = (size == 2'b01 & off[0]) | (size[1] & |off);
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    req       = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: if (access & ~mis) begin
        req = 1'b1;
        done = mem_ack;
        stall = ~mem_ack;
        state_d = mem_ack ? IDLE : WAIT;
        cnt_d = mem_ack ? '0 : CW'(1);
      end
      WAIT: begin
        req = 1'b1;
        done = mem_ack;
        stall = ~mem_ack;
        cnt_d = mem_ack ? '0 : cnt_q + 1'b1;
        state_d = mem_ack ? IDLE : (cnt_d == CW'(TIMEOUT)) ? ERR : WAIT;
        bus_err_d = bus_err_q | (~mem_ack & cnt_d == CW'(TIMEOUT));
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end
  // Load lane selection and extension; funct3[2] selects zero extension.
  always_comb begin
    shifted   = mem_rdata >> {off, 3'b000};
    half      = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    fmt       = size == 2'b00 ? {{24{~MemoryOpM[2] & shifted[7]}}, shifted[7:0]} :
                size == 2'b01 ? {{16{~MemoryOpM[2] & half[15]}}, half} : mem_rdata;
    ReadDataM = done ? fmt : '0;
    mem_addr  = {ALUResultM[31:2], 2'b00};
    mem_we    = MemWriteM;
    mem_wdata = size == 2'b00 ? {4{WriteDataM[7:0]}} :
                size == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
    mem_wstrb = ~MemWriteM ? 4'b0000 :
                size == 2'b00 ? 4'b0001 << off :
                size == 2'b01 ? 4'b0011 << off : 4'b1111;
    mem_req      = req & ~reset;
    MemStallM    = stall & ~reset;
    misaligned_o = (state_q == IDLE) & access & mis;
    bus_err_o    = bus_err_q;
    reg_write_w_d = stall ? 1'b0 : RegWriteM;
    rd_w_d        = stall ? '0 : RdM;
    result_w_d    = stall ? '0 :
                    ResultSrcM == 2'b01 ? ReadDataM :
                    ResultSrcM == 2'b10 ? PCPlus4M : ALUResultM;
    RegWriteW = reg_write_w_q;
    RdW       = rd_w_q;
    ResultW   = result_w_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bus_err_q     <= 1'b0;
      reg_write_w_q <= 1'b0;
      rd_w_q        <= '0;
      result_w_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_err_q     <= bus_err_d;
      reg_write_w_q <= reg_write_w_d;
      rd_w_q        <= rd_w_d;
      result_w_q    <= result_w_d;
    end
  end
endmodule

// File: tb/tb_memory_top.sv
// tb_memory_top: directed and randomized transactions against a
// transaction-level reference model of the memory stage.
module tb_memory_top;
  logic        clk = 1'b0, reset;
  logic        RegWriteM, MemWriteM, mem_req, mem_we, mem_ack, MemStallM;
  logic        misaligned_o, bus_err_o, RegWriteW;
  logic [1:0]  ResultSrcM;
  logic [2:0]  MemoryOpM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ReadDataM, ResultW;
  logic [3:0]  mem_wstrb;
  logic [4:0]  RdM, RdW;
  int          n_vec = 0, n_bad = 0;
  logic        err_model = 1'b0;
  logic [2:0]  load_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  memory_top dut (
    .clk(clk), .reset(reset), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .MemoryOpM(MemoryOpM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .MemStallM(MemStallM), .ReadDataM(ReadDataM),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o), .RegWriteW(RegWriteW),
    .RdW(RdW), .ResultW(ResultW)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] s, v, lim;
    if (op[1]) return r;
    s   = r >> (8 * a[1:0]);
    v   = op[0] ? s & 32'hFFFF : s & 32'hFF;
    lim = op[0] ? 32'h8000 : 32'h80;
    return (!op[2] && v >= lim) ? v - 2 * lim : v;
  endfunction
  task automatic txn(input logic st, input logic [1:0] rs, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                     input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                     input int w, input logic to);
    logic acc, mis, ok;
    int ns, o, sz;
    logic [31:0] lv, strb, wexp, res;
    o   = int'(a[1:0]);
    sz  = int'(op[1:0]);
    acc = st || rs == 2'b01;
    mis = (sz == 1 && o % 2 == 1) || (sz >= 2 && o != 0);
    ok  = acc && !mis;
    ns  = ok ? (to ? 16 : w) : 0;
    lv  = (ok && !to && !st) ? load_val(op, a, rdat) : 32'd0;
    strb = !st ? 0 : sz == 0 ? 32'd1 << o : sz == 1 ? 32'd3 << o : 32'd15;
    wexp = sz == 0 ? {24'd0, wd[7:0]} * 32'h01010101 :
           sz == 1 ? {16'd0, wd[15:0]} * 32'h00010001 : wd;
    MemWriteM = st; ResultSrcM = rs; MemoryOpM = op; ALUResultM = a; WriteDataM = wd;
    mem_rdata = rdat; PCPlus4M = pc; RdM = rd; RegWriteM = rw;
    for (int c = 0; c <= ns; c++) begin
      mem_ack = ok && !to && c == w;
      @(negedge clk);
      chk("stall", {31'd0, MemStallM}, {31'd0, c < ns});
      chk("req", {31'd0, mem_req}, {31'd0, ok && (c < ns || !to)});
      if (c == 0) begin
        chk("misaligned", {31'd0, misaligned_o}, {31'd0, mis && acc});
        if (ok) begin
          chk("addr", mem_addr, a & ~32'd3);
          chk("we", {31'd0, mem_we}, {31'd0, st});
          chk("wstrb", {28'd0, mem_wstrb}, strb);
          if (st) chk("wdata", mem_wdata, wexp);
        end
      end
      if (c == ns && !st) chk("rdata", ReadDataM, lv);
      @(posedge clk);
      #1;
      if (c < ns) begin
        chk("bubble_ctl", {26'd0, RegWriteW, RdW}, 32'd0);
        chk("bubble_res", ResultW, 32'd0);
      end
    end
    mem_ack = 1'b0;
    if (ok && to) err_model = 1'b1;
    res = rs == 2'b01 ? lv : rs == 2'b10 ? pc : a;
    chk("regw", {31'd0, RegWriteW}, {31'd0, rw});
    chk("rdw", {27'd0, RdW}, {27'd0, rd});
    chk("result", ResultW, res);
    chk("bus_err", {31'd0, bus_err_o}, {31'd0, err_model});
  endtask
  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 0; RegWriteM = 0; MemWriteM = 0;
    ResultSrcM = 0; MemoryOpM = 0; ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0; RdM = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_regw", {31'd0, RegWriteW}, 32'd0);
    chk("rst_rdw", {27'd0, RdW}, 32'd0);
    chk("rst_result", ResultW, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    txn(0, 2'b01, 3'd2, 32'h100, 0, 32'hDEADBEEF, 32'h44, 5'd5, 1, 0, 0);
    txn(0, 2'b01, 3'd0, 32'h103, 0, 32'h80123456, 32'h48, 5'd7, 1, 3, 0);
    txn(0, 2'b01, 3'd4, 32'h103, 0, 32'h80123456, 32'h4C, 5'd7, 1, 3, 0);
    txn(1, 2'b00, 3'd1, 32'h202, 32'h1234ABCD, 0, 32'h50, 5'd0, 0, 1, 0);
    txn(0, 2'b01, 3'd2, 32'h101, 0, 32'h11111111, 32'h54, 5'd9, 1, 0, 0);
    txn(0, 2'b01, 3'd2, 32'h400, 0, 32'h22222222, 32'h58, 5'd3, 1, 0, 1);
    txn(0, 2'b10, 3'd0, 32'h8, 0, 0, 32'h5C, 5'd1, 1, 0, 0);
    MemWriteM = 0; ResultSrcM = 2'b01; MemoryOpM = 3'd2; ALUResultM = 32'h300; RdM = 5'd6;
    RegWriteM = 1; mem_ack = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, MemStallM}, 32'd0);
    chk("rst_w_ctl", {26'd0, RegWriteW, RdW}, 32'd0);
    chk("rst_w_res", ResultW, 32'd0);
    chk("rst_err", {31'd0, bus_err_o}, 32'd0);
    err_model = 1'b0;
    ResultSrcM = 2'b00;
    @(posedge clk);
    #1 reset = 1'b0;
    txn(0, 2'b01, 3'd5, 32'h302, 0, 32'hF00D1234, 32'h60, 5'd6, 1, 2, 0);
    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [1:0] rs;
      logic [2:0] op;
      kind = $urandom_range(0, 2);
      rs = kind == 1 ? 2'b01 : kind == 2 ? 2'b00 : ($urandom_range(0, 1) ? 2'b10 : 2'b11);
      op = kind == 2 ? 3'($urandom_range(0, 2)) : load_ops[$urandom_range(0, 4)];
      txn(kind == 2, rs, op, $urandom, $urandom, $urandom, $urandom, 5'($urandom),
          1'($urandom), $urandom_range(0, 4), $urandom_range(0, 19) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
